fetch_stage: RTL and testbench

Parametrised instruction-fetch front end; successor to the fixed PC + clock-divider + instruction-memory path.
- Replaces the divided clock with a programmable fetch tick (clock-enable) on the single system clock.
- Drives a synchronous instruction memory with 1-cycle read latency.
- Adds jump/branch redirect, flush, and a valid/ready handshake toward the controller/decode stage.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: programmable fetch tick, 1-cycle synchronous imem, redirect/flush, valid/ready out.
// Optional FETCH_PERF_EN adds saturating handshake and flush counters.
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter int              ADDR_W   = 10,
    parameter int              INSTR_W  = 32,
    parameter int              DIV_W    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [DIV_W-1:0]   div_ratio,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetches,
    output logic [31:0]        perf_flushes
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_cnt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_req_pc;
    logic [PC_W-1:0]    r_out_pc;
    logic [INSTR_W-1:0] r_out_instr;
    logic               r_out_valid;

    logic               w_tick;
    logic               w_req;
    logic [PC_W-1:0]    w_redir_pc;

    // A div_ratio smaller than the running count is missed until the counter wraps naturally.
    assign w_tick     = (r_cnt == div_ratio);
    assign w_redir_pc = redirect_pc & ~PC_W'(3);
    assign w_req      = rst && (r_state == S_IDLE) && ena && w_tick && !redirect_valid;

    // The request is issued combinationally in IDLE so the data lands during WAIT.
    assign imem_en   = w_req;
    assign imem_addr = w_req ? r_pc[ADDR_W+1:2] : '0;

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign pc        = r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end else if (w_req) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + PC_W'(4);
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_state <= S_IDLE;
                    end else begin
                        r_out_instr <= imem_rdata;
                        r_out_pc    <= r_req_pc;
                        r_out_valid <= 1'b1;
                        r_state     <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (redirect_valid) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= w_redir_pc;
                        r_state     <= S_IDLE;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetches;
    logic [31:0] r_perf_flushes;

    // A redirect coinciding with out_ready still counts as a consumed instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetches <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (r_state == S_VALID && out_ready && r_perf_fetches != 32'hFFFF_FFFF)
                r_perf_fetches <= r_perf_fetches + 32'd1;
            if ((r_state == S_WAIT || r_state == S_VALID) && redirect_valid &&
                r_perf_flushes != 32'hFFFF_FFFF)
                r_perf_flushes <= r_perf_flushes + 32'd1;
        end
    end

    assign perf_fetches = r_perf_fetches;
    assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed phases plus randomized traffic against a transaction-level model.
module tb_fetch_stage;
    localparam int PC_W = 32, ADDR_W = 10, INSTR_W = 32, DIV_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic [DIV_W-1:0]   div_ratio;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    pc;
`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetches;
    logic [31:0]        perf_flushes;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(PC_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DIV_W(DIV_W),
                  .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .ena(ena), .div_ratio(div_ratio),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .pc(pc)
`ifdef FETCH_PERF_EN
        , .perf_fetches(perf_fetches), .perf_flushes(perf_flushes)
`endif
    );

    logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    int vecs = 0, fails = 0;

    // Model: at most one fetch outstanding; an instruction is either in flight, presented, or absent.
    bit          m_v, m_inflight;
    logic [31:0] m_pc, m_req_pc, m_out_pc, m_out_instr;
    int          m_cnt;
    longint      m_fetches, m_flushes;
    bit          last_en, last_v;
    logic [ADDR_W-1:0] last_addr;
    int          n_hs;
    logic [31:0] hs_pcs [$];
    logic [31:0] pc0, ins0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_inflight = 0; m_pc = 32'h0; m_cnt = 0;
        m_fetches = 0; m_flushes = 0;
    endtask

    task automatic cycle();
        bit tick, en_exp;
        @(negedge clk);
        tick   = (m_cnt == int'(div_ratio));
        en_exp = !m_v && !m_inflight && ena && tick && !redirect_valid;
        chk("out_valid", out_valid, m_v);
        if (m_v) begin
            chk("out_pc", out_pc, m_out_pc);
            chk("out_instr", out_instr, m_out_instr);
        end
        chk("pc", pc, m_pc);
        chk("imem_en", imem_en, en_exp);
        if (imem_en) chk("imem_addr", imem_addr, m_pc[ADDR_W+1:2]);
`ifdef FETCH_PERF_EN
        chk("perf_fetches", perf_fetches, m_fetches[31:0]);
        chk("perf_flushes", perf_flushes, m_flushes[31:0]);
`endif
        last_en = imem_en; last_v = out_valid; last_addr = imem_addr;
        if (out_valid && out_ready) begin n_hs++; hs_pcs.push_back(out_pc); end
        if (redirect_valid) begin
            if (m_v || m_inflight) m_flushes++;
            if (m_v && out_ready) m_fetches++;
            m_v = 0; m_inflight = 0; m_pc = redirect_pc & ~32'd3;
        end else if (m_v) begin
            if (out_ready) begin m_v = 0; m_fetches++; end
        end else if (m_inflight) begin
            m_inflight = 0; m_v = 1; m_out_pc = m_req_pc;
            m_out_instr = mem[m_req_pc[ADDR_W+1:2]];
        end else if (en_exp) begin
            m_inflight = 1; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
        end
        m_cnt = tick ? 0 : (m_cnt + 1) % (1 << DIV_W);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        rst = 1'b0; ena = 1'b1; div_ratio = '0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b1; n_hs = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_imem_en", imem_en, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_pc", pc, 0);
        @(posedge clk); #1;
        rst = 1'b1; model_reset();

        // Back-to-back fetches, tick every cycle.
        repeat (12) cycle();
        chk("p1_handshakes", n_hs, 4);
        for (int i = 0; i < 4 && i < hs_pcs.size(); i++) chk("p1_out_pc_seq", hs_pcs[i], i * 4);

        // Slow tick.
        div_ratio = 4'd3;
        repeat (40) cycle();

        // Back-pressure: output held stable, no new requests.
        div_ratio = 4'd0; out_ready = 1'b0;
        for (int k = 0; k < 20 && !last_v; k++) cycle();
        chk("p3_valid_seen", last_v, 1);
        pc0 = out_pc; ins0 = out_instr;
        repeat (10) cycle();
        chk("p3_hold_pc", out_pc, pc0);
        chk("p3_hold_instr", out_instr, ins0);
        out_ready = 1'b1;
        repeat (6) cycle();

        // Redirect during WAIT drops the in-flight data.
        last_en = 0;
        for (int k = 0; k < 20 && !last_en; k++) cycle();
        chk("p4_req_seen", last_en, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect_valid = 1'b0; n_hs = 0; hs_pcs.delete(); last_en = 0;
        for (int k = 0; k < 20 && !last_en; k++) cycle();
        chk("p4_redir_addr", last_addr, 10'h40);
        repeat (3) cycle();
        chk("p4_hs_count", hs_pcs.size(), 1);
        if (hs_pcs.size() > 0) chk("p4_redir_out_pc", hs_pcs[0], 32'h100);

        // Asynchronous reset while an instruction is presented.
        out_ready = 1'b0; last_v = 0;
        for (int k = 0; k < 20 && !last_v; k++) cycle();
        chk("p5_valid_seen", last_v, 1);
        #2 rst = 1'b0;
        #1;
        chk("p5_async_valid", out_valid, 0);
        chk("p5_async_pc", pc, 0);
        chk("p5_async_en", imem_en, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; model_reset(); out_ready = 1'b1; n_hs = 0; hs_pcs.delete();
        repeat (8) cycle();
        chk("p5_restart_hs", n_hs, 2);
        if (hs_pcs.size() > 0) chk("p5_restart_pc", hs_pcs[0], 0);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0; hs_pcs.delete();
        repeat (8) cycle();
        chk("p6_hs_count", hs_pcs.size(), 2);
        if (hs_pcs.size() >= 2) begin
            chk("p6_top_pc", hs_pcs[0], 32'hFFFF_FFFC);
            chk("p6_wrap_pc", hs_pcs[1], 32'h0);
        end

        // Randomized traffic.
        repeat (400) begin
            ena            = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 49) == 0) div_ratio = DIV_W'($urandom_range(0, 5));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
